// File: rtl/control_pop_vc_pkg.sv
// Shared definitions for the VC-pop arbiter: parameter defaults, source
// encoding of a popped word and the pipeline stage payload.
package control_pop_vc_pkg;

  localparam int unsigned BITS_DEF     = 6;
  localparam int unsigned PESO_VC0_DEF = 4;

  // Which VC a word in flight was popped from.
  localparam logic FUENTE_VC0 = 1'b0;
  localparam logic FUENTE_VC1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic fuente;
  } etapa_t;

endpackage

// File: rtl/control_pop_vc_contador_peso.sv
// Anti-starvation counter: counts consecutive VC0 grants while VC1 waits and
// requests that the next eligible grant go to VC1 once PESO is reached.
// Ports:
//   clk, reset_L         clock, asynchronous active-low reset
//   vc1_empty            VC1 FIFO empty flag
//   grant_vc0/grant_vc1  grants issued this cycle
//   forzar_vc1           combinational: VC1 must win the next eligible grant
module contador_peso #(
  parameter int unsigned PESO = 4
) (
  input  logic clk,
  input  logic reset_L,
  input  logic vc1_empty,
  input  logic grant_vc0,
  input  logic grant_vc1,
  output logic forzar_vc1
);

  localparam int unsigned CW = $clog2(PESO + 1);

  logic [CW-1:0] cuenta_vc0;

  // Saturating count of VC0 grants; cleared when VC1 has nothing or is served.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cuenta_vc0 <= '0;
    end else if (vc1_empty || grant_vc1) begin
      cuenta_vc0 <= '0;
    end else if (grant_vc0 && (cuenta_vc0 != CW'(PESO))) begin
      cuenta_vc0 <= cuenta_vc0 + CW'(1);
    end
  end

  assign forzar_vc1 = (cuenta_vc0 == CW'(PESO));

endmodule

// File: rtl/control_pop_vc.sv
// Pops words from two virtual-channel FIFOs and pushes them to D0 or D1
// according to the word's MSB. Two-cycle latency, one word per cycle.
// Ports:
//   clk, reset_L                    clock, asynchronous active-low reset
//   vc0_empty, vc1_empty            source FIFO empty flags
//   vc0_data, vc1_data              source read data (valid cycle after pop)
//   d0_almost_full, d1_almost_full  destination back-pressure
//   pop_vc0, pop_vc1                combinational pops
//   push_d0, push_d1, data_out      registered destination write
// Optional: define CONTROL_POP_VC_ANTIHAMBRE_EN to limit consecutive VC0
// grants to PESO_VC0 while VC1 waits; otherwise VC0 has strict priority.
module control_pop_vc
  import control_pop_vc_pkg::*;
#(
  parameter int unsigned BITS     = BITS_DEF,
  parameter int unsigned PESO_VC0 = PESO_VC0_DEF
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            vc0_empty,
  input  logic            vc1_empty,
  input  logic [BITS-1:0] vc0_data,
  input  logic [BITS-1:0] vc1_data,
  input  logic            d0_almost_full,
  input  logic            d1_almost_full,
  output logic            pop_vc0,
  output logic            pop_vc1,
  output logic            push_d0,
  output logic            push_d1,
  output logic [BITS-1:0] data_out
);

  // A zero weight would leave VC0 without any grant while VC1 waits.
  if (PESO_VC0 == 0) begin : g_peso_invalido
    $error("control_pop_vc: PESO_VC0 must be at least 1");
  end

  logic            grant_ok;
  logic            forzar_vc1;
  etapa_t          etapa;
  logic [BITS-1:0] palabra;

  assign grant_ok = reset_L & ~d0_almost_full & ~d1_almost_full;

`ifdef CONTROL_POP_VC_ANTIHAMBRE_EN
  contador_peso #(
    .PESO (PESO_VC0)
  ) u_contador_peso (
    .clk        (clk),
    .reset_L    (reset_L),
    .vc1_empty  (vc1_empty),
    .grant_vc0  (pop_vc0),
    .grant_vc1  (pop_vc1),
    .forzar_vc1 (forzar_vc1)
  );
`else
  assign forzar_vc1 = 1'b0;
`endif

  // VC0 wins unless empty or the starvation limit hands this grant to VC1.
  assign pop_vc0 = grant_ok & ~vc0_empty & ~(forzar_vc1 & ~vc1_empty);
  assign pop_vc1 = grant_ok & ~vc1_empty & (vc0_empty | forzar_vc1);

  // Source data arrives one cycle after the pop; pick it by recorded source.
  assign palabra = (etapa.fuente == FUENTE_VC1) ? vc1_data : vc0_data;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      etapa    <= '0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
      data_out <= '0;
    end else begin
      etapa.valid  <= pop_vc0 | pop_vc1;
      etapa.fuente <= pop_vc1 ? FUENTE_VC1 : FUENTE_VC0;
      if (etapa.valid) begin
        data_out <= palabra;
        push_d0  <= ~palabra[BITS-1];
        push_d1  <= palabra[BITS-1];
      end else begin
        push_d0  <= 1'b0;
        push_d1  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_pop_vc.sv
// Directed bench for control_pop_vc with behavioural models of the two VC
// FIFOs. Cycle 0 is the first cycle with reset_L=1; outputs are sampled 1
// time unit after the falling edge that starts each cycle.
module tb_control_pop_vc;

  localparam int unsigned BITS = 6;

  logic            clk = 1'b0;
  logic            reset_L = 1'b0;
  logic            vc0_empty = 1'b1;
  logic            vc1_empty = 1'b1;
  logic [BITS-1:0] vc0_data = '0;
  logic [BITS-1:0] vc1_data = '0;
  logic            d0_almost_full = 1'b0;
  logic            d1_almost_full = 1'b0;
  logic            pop_vc0, pop_vc1, push_d0, push_d1;
  logic [BITS-1:0] data_out;

  logic [BITS-1:0] q0[$];
  logic [BITS-1:0] q1[$];

  int checks = 0;
  int errors = 0;

  control_pop_vc #(.BITS(BITS), .PESO_VC0(4)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  // FIFO models: read data appears the cycle after the pop.
  always @(posedge clk) begin
    if (pop_vc0 && q0.size() != 0) begin
      vc0_data <= q0[0];
      void'(q0.pop_front());
    end
    if (pop_vc1 && q1.size() != 0) begin
      vc1_data <= q1[0];
      void'(q1.pop_front());
    end
    vc0_empty <= (q0.size() == 0);
    vc1_empty <= (q1.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Check one cycle of outputs, then advance to the start of the next cycle.
  task automatic paso(input string tag, input logic e_p0, input logic e_p1,
                      input logic e_d0, input logic e_d1, input logic [BITS-1:0] e_data);
    #1;
    check({tag, " pop_vc0"}, 32'(pop_vc0), 32'(e_p0));
    check({tag, " pop_vc1"}, 32'(pop_vc1), 32'(e_p1));
    check({tag, " push_d0"}, 32'(push_d0), 32'(e_d0));
    check({tag, " push_d1"}, 32'(push_d1), 32'(e_d1));
    check({tag, " data_out"}, 32'(data_out), 32'(e_data));
    check({tag, " pop_on_empty"}, 32'((pop_vc0 & vc0_empty) | (pop_vc1 & vc1_empty)), 32'd0);
    @(negedge clk);
  endtask

  // Enter reset and flush the FIFO models; caller loads them afterwards.
  task automatic entrar_reset();
    @(negedge clk);
    reset_L        = 1'b0;
    d0_almost_full = 1'b0;
    d1_almost_full = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // Let the empty flags settle, check the reset state, release on a falling edge.
  task automatic salir_reset(input string tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, " rst pop_vc0"}, 32'(pop_vc0), 32'd0);
    check({tag, " rst pop_vc1"}, 32'(pop_vc1), 32'd0);
    check({tag, " rst push_d0"}, 32'(push_d0), 32'd0);
    check({tag, " rst push_d1"}, 32'(push_d1), 32'd0);
    check({tag, " rst data_out"}, 32'(data_out), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [BITS-1:0] hist[10];
    logic            g1;
    int              n0, n1;
    logic [BITS-1:0] ed;

    // Two VC0 words routed to D0 then D1.
    entrar_reset();
    q0.push_back(6'h05);
    q0.push_back(6'h25);
    salir_reset("t1");
    paso("t1 c0", 1, 0, 0, 0, 6'h00);
    paso("t1 c1", 1, 0, 0, 0, 6'h00);
    paso("t1 c2", 0, 0, 1, 0, 6'h05);
    paso("t1 c3", 0, 0, 0, 1, 6'h25);
    paso("t1 c4", 0, 0, 0, 0, 6'h25);

    // VC0 empty, single VC1 word.
    entrar_reset();
    q1.push_back(6'h3F);
    salir_reset("t2");
    paso("t2 c0", 0, 1, 0, 0, 6'h00);
    paso("t2 c1", 0, 0, 0, 0, 6'h00);
    paso("t2 c2", 0, 0, 0, 1, 6'h3F);
    paso("t2 c3", 0, 0, 0, 0, 6'h3F);

    // Both VCs busy: strict priority, or VC0x4 then VC1 with the limiter.
    entrar_reset();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(32 + i));
    end
    salir_reset("t3");
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 10; k++) begin
`ifdef CONTROL_POP_VC_ANTIHAMBRE_EN
      g1 = ((k % 5) == 4);
`else
      g1 = 1'b0;
`endif
      if (g1) begin
        hist[k] = 6'(32 + n1);
        n1++;
      end else begin
        hist[k] = 6'(n0);
        n0++;
      end
      ed = (k >= 2) ? hist[k-2] : 6'h00;
      paso($sformatf("t3 c%0d", k), ~g1, g1,
           (k >= 2) && !ed[BITS-1], (k >= 2) && ed[BITS-1], ed);
    end

    // Back-pressure from cycle 3: pops stop, in-flight words still pushed.
    entrar_reset();
    q0.push_back(6'h01);
    q0.push_back(6'h22);
    q0.push_back(6'h03);
    q0.push_back(6'h24);
    q0.push_back(6'h05);
    q0.push_back(6'h06);
    salir_reset("t4");
    paso("t4 c0", 1, 0, 0, 0, 6'h00);
    paso("t4 c1", 1, 0, 0, 0, 6'h00);
    paso("t4 c2", 1, 0, 1, 0, 6'h01);
    d1_almost_full = 1'b1;
    paso("t4 c3", 0, 0, 0, 1, 6'h22);
    paso("t4 c4", 0, 0, 1, 0, 6'h03);
    paso("t4 c5", 0, 0, 0, 0, 6'h03);
    d1_almost_full = 1'b0;
    paso("t4 c6", 1, 0, 0, 0, 6'h03);
    paso("t4 c7", 1, 0, 0, 0, 6'h03);
    paso("t4 c8", 1, 0, 0, 1, 6'h24);

    // Reset after pops: outputs clear at once, in-flight words are dropped.
    entrar_reset();
    q0.push_back(6'h11);
    q0.push_back(6'h32);
    q0.push_back(6'h13);
    salir_reset("t5");
    paso("t5 c0", 1, 0, 0, 0, 6'h00);
    paso("t5 c1", 1, 0, 0, 0, 6'h00);
    paso("t5 c2", 1, 0, 1, 0, 6'h11);
    reset_L = 1'b0;
    paso("t5 c3", 0, 0, 0, 0, 6'h00);
    reset_L = 1'b1;
    paso("t5 c4", 0, 0, 0, 0, 6'h00);
    paso("t5 c5", 0, 0, 0, 0, 6'h00);
    paso("t5 c6", 0, 0, 0, 0, 6'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pop_vc.md
CONTROL_POP_VC -- requirements
Module: control_pop_vc

Interface
REQ-001 The block SHALL have parameter BITS, default 6, meaning VC/destination word width.
REQ-002 The block SHALL have parameter PESO_VC0, default 4, meaning maximum consecutive VC0 grants while VC1 waits.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset_L  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port vc0_empty  input  1  VC0 FIFO empty flag.
REQ-006 The block SHALL have port vc1_empty  input  1  VC1 FIFO empty flag.
REQ-007 The block SHALL have port vc0_data  input  BITS  VC0 FIFO read data, valid the cycle after pop.
REQ-008 The block SHALL have port vc1_data  input  BITS  VC1 FIFO read data, valid the cycle after pop.
REQ-009 The block SHALL have port d0_almost_full  input  1  D0 FIFO back-pressure.
REQ-010 The block SHALL have port d1_almost_full  input  1  D1 FIFO back-pressure.
REQ-011 The block SHALL have port pop_vc0  output  1  combinational pop to VC0.
REQ-012 The block SHALL have port pop_vc1  output  1  combinational pop to VC1.
REQ-013 The block SHALL have port push_d0  output  1  registered push to D0.
REQ-014 The block SHALL have port push_d1  output  1  registered push to D1.
REQ-015 The block SHALL have port data_out  output  BITS  registered word to D0/D1.

Function
REQ-016 Grant allowed in a cycle only when reset_L=1, d0_almost_full=0 and d1_almost_full=0.
REQ-017 At most one of pop_vc0/pop_vc1 SHALL be high in any cycle.
REQ-018 Base priority: pop_vc0 when vc0_empty=0; else pop_vc1 when vc1_empty=0; else no pop.
REQ-019 Pipeline: pop in cycle N -> word captured from popped VC at end of N+1 -> push_dX and data_out valid in N+2; latency 2, throughput 1 word/cycle.
REQ-020 Routing: data bit [BITS-1]=0 -> push_d0, =1 -> push_d1; never both.
REQ-021 Back-pressure asserted mid-stream SHALL stop new pops only; words already popped (up to 2) SHALL still be pushed.
REQ-022 No pop SHALL occur on an empty VC; flags are sampled the same cycle pop is driven.
REQ-023 data_out SHALL hold its last value when no push occurs.

Reset
REQ-024 reset_L=0 SHALL immediately clear push_d0, push_d1, data_out (to 0), pipeline valid/source regs and the grant counter.
REQ-025 pop_vc0, pop_vc1 SHALL be 0 while reset_L=0; in-flight words at reset are discarded.
REQ-026 First pop may occur in the first cycle with reset_L=1.

Configuration
REQ-027 Macro CONTROL_POP_VC_ANTIHAMBRE_EN defined: counter cuenta_vc0 increments on each VC0 grant while vc1_empty=0; on reaching PESO_VC0 the next eligible grant SHALL go to VC1, then counter clears; counter clears whenever vc1_empty=1 or VC1 granted.
REQ-028 Macro undefined: strict VC0 priority, no counter logic synthesized.

Structure
REQ-029 Shared package SHALL hold BITS default, PESO_VC0 default and the source encoding constants (FUENTE_VC0, FUENTE_VC1).
REQ-030 One sub-module, contador_peso, SHALL implement the anti-starvation counter (instantiated only under the macro).

Verification
REQ-031 Reset release, VC0 holds 0x05, 0x25, D not full -> pop_vc0 cycles 0,1; push_d0 data 0x05 cycle 2; push_d1 data 0x25 cycle 3.
REQ-032 Both VCs non-empty, macro off, 10 cycles -> 10 VC0 pops, 0 VC1 pops.
REQ-033 Both VCs non-empty, macro on, PESO_VC0=4 -> grant pattern VC0x4, VC1, VC0x4, VC1.
REQ-034 d1_almost_full rises in cycle 3 of steady stream -> no pop from cycle 3; 2 in-flight words still pushed in cycles 3,4.
REQ-035 reset_L low in cycle after a pop -> push_d0/push_d1/data_out 0 immediately, no push of the popped word after release.
REQ-036 VC0 empty, VC1 holds 0x3F -> pop_vc1 once, push_d1 data 0x3F two cycles later, then idle.
